led_blink_ctrl: RTL and testbench

Multi-channel LED pattern generator and parametrised successor of the single-LED 1 s blinker. A shared prescaler derives a slow tick from the board clock. Each of CH channels independently runs OFF, ON, BLINK (programmable half-period in ticks) or PWM (8-bit duty brightness). The block sits between the board-level register/config logic and the LED pins.

---
 rtl/led_blink_ctrl.sv | 133 +++++++++++++
 tb/tb_led_blink_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_blink_ctrl.sv
// led_blink_ctrl: multi-channel LED pattern generator.
// A shared prescaler produces a slow TICK from CLK_50M. Each channel runs
// OFF, ON, BLINK (half-period in ticks) or PWM (8-bit duty over a shared
// 256-clock base). LED outputs are registered.
module led_blink_ctrl #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 1000,
  parameter int unsigned CH      = 4,
  parameter int unsigned HALF_W  = 16,
  localparam int unsigned CH_W   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic              CLK_50M,
  input  logic              RST,
  input  logic              CFG_WE,
  input  logic [CH_W-1:0]   CFG_CH,
  input  logic [1:0]        CFG_MODE,
  input  logic [HALF_W-1:0] CFG_HALF,
  input  logic [7:0]        CFG_DUTY,
  input  logic              SYNC,
  output logic              TICK,
  output logic [CH-1:0]     LED
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_div_check
    $error("led_blink_ctrl: CLK_HZ/TICK_HZ must be at least 2");
  end

  if ((CH < 1) || (CH > 16)) begin : g_ch_check
    $error("led_blink_ctrl: CH must be in 1..16");
  end

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_e;

  logic [PRE_W-1:0]  pre_cnt;
  logic [7:0]        pwm_cnt;
  logic              tick;
  logic              cfg_ok;
  logic [CH-1:0]     wr_hit;
  logic [CH-1:0]     ph_r;
  mode_e             mode_r  [CH];
  logic [HALF_W-1:0] half_r  [CH];
  logic [7:0]        duty_r  [CH];
  logic [HALF_W-1:0] bcnt_r  [CH];
  logic [HALF_W-1:0] half_m1 [CH];

  // Tick at the last prescaler count; suppressed while SYNC realigns.
  always_comb begin
    tick = (pre_cnt == PRE_W'(DIV - 1)) && !SYNC;
    TICK = tick;
  end

  // Decode the config write; out-of-range channels hit nothing.
  always_comb begin
    cfg_ok = (32'(CFG_CH) < CH);
    wr_hit = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      wr_hit[i] = CFG_WE && cfg_ok && (CFG_CH == CH_W'(i));
    end
  end

  // Terminal blink count per channel; a half-period of 0 behaves as 1.
  always_comb begin
    for (int unsigned i = 0; i < CH; i++) begin
      half_m1[i] = (half_r[i] == '0) ? '0 : (half_r[i] - 1'b1);
    end
  end

  // Shared prescaler and free-running PWM base; SYNC restarts both.
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else if (SYNC) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= (pre_cnt == PRE_W'(DIV - 1)) ? '0 : (pre_cnt + 1'b1);
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Per-channel config, blink phase and registered LED drive.
  // A write or SYNC clears the blink counter ahead of any same-cycle tick.
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < CH; i++) begin
        mode_r[i] <= MODE_OFF;
        half_r[i] <= '0;
        duty_r[i] <= '0;
        bcnt_r[i] <= '0;
      end
      ph_r <= '0;
      LED  <= '0;
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        if (wr_hit[i]) begin
          mode_r[i] <= mode_e'(CFG_MODE);
          half_r[i] <= CFG_HALF;
          duty_r[i] <= CFG_DUTY;
        end

        if (wr_hit[i] || SYNC) begin
          bcnt_r[i] <= '0;
          ph_r[i]   <= 1'b0;
        end else if (tick) begin
          if (bcnt_r[i] >= half_m1[i]) begin
            bcnt_r[i] <= '0;
            ph_r[i]   <= ~ph_r[i];
          end else begin
            bcnt_r[i] <= bcnt_r[i] + 1'b1;
          end
        end

        case (mode_r[i])
          MODE_OFF:   LED[i] <= 1'b0;
          MODE_ON:    LED[i] <= 1'b1;
          MODE_BLINK: LED[i] <= ph_r[i];
          MODE_PWM:   LED[i] <= (pwm_cnt < duty_r[i]);
          default:    LED[i] <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Testbench for led_blink_ctrl: directed stimulus pushes expected LED/TICK
// snapshots (tagged with the cycle they are due) into a scoreboard queue;
// a monitor on the falling edge pops and compares entries as they fall due.
module tb_led_blink_ctrl;

  localparam logic [1:0] M_OFF   = 2'd0;
  localparam logic [1:0] M_ON    = 2'd1;
  localparam logic [1:0] M_BLINK = 2'd2;
  localparam logic [1:0] M_PWM   = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [2:0]  cfg_ch;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_half;
  logic [7:0]  cfg_duty;
  logic        sync;
  logic        tick;
  logic [4:0]  led;

  typedef struct {
    int unsigned cyc;
    logic [4:0]  mask;
    logic [4:0]  led;
    logic        ct;
    logic        t;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned n_tests = 0;
  int unsigned n_fail = 0;
  int unsigned base;
  logic        flush = 1'b0;

  led_blink_ctrl #(
    .CLK_HZ (1000),
    .TICK_HZ(100),
    .CH     (5),
    .HALF_W (16)
  ) dut (
    .CLK_50M (clk),
    .RST     (rst),
    .CFG_WE  (cfg_we),
    .CFG_CH  (cfg_ch),
    .CFG_MODE(cfg_mode),
    .CFG_HALF(cfg_half),
    .CFG_DUTY(cfg_duty),
    .SYNC    (sync),
    .TICK    (tick),
    .LED     (led)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every entry due this cycle; on flush, leftovers fail.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (flush) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s never checked: due cyc %0d, now %0d", sb[i].name, sb[i].cyc, cyc);
        sb.delete(i);
      end else if (sb[i].cyc <= cyc) begin
        n_tests++;
        if (sb[i].cyc < cyc) begin
          n_fail++;
          $display("FAIL %s late: due cyc %0d, now %0d", sb[i].name, sb[i].cyc, cyc);
        end else if (((led & sb[i].mask) !== (sb[i].led & sb[i].mask)) ||
                     (sb[i].ct && (tick !== sb[i].t))) begin
          n_fail++;
          $display("FAIL %s cyc=%0d: LED=%b TICK=%b, required LED=%b (mask %b) TICK=%b%s",
                   sb[i].name, cyc, led, tick, sb[i].led, sb[i].mask, sb[i].t,
                   sb[i].ct ? "" : " (not checked)");
        end
        sb.delete(i);
      end
    end
  end

  task automatic chk(input int unsigned tgt, input string nm, input logic [4:0] mask,
                     input logic [4:0] exp_led, input logic ct, input logic t);
    exp_t e;
    e.cyc  = tgt;
    e.mask = mask;
    e.led  = exp_led;
    e.ct   = ct;
    e.t    = t;
    e.name = nm;
    sb.push_back(e);
  endtask

  // Called at #1 after a rising edge; returns at #1 after edge cyc == t.
  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one cycle of config/SYNC; the next rising edge samples it.
  task automatic apply(input logic [2:0] ch, input logic [1:0] mode, input logic [15:0] half,
                       input logic [7:0] duty, input logic we, input logic sy);
    cfg_ch   = ch;
    cfg_mode = mode;
    cfg_half = half;
    cfg_duty = duty;
    cfg_we   = we;
    sync     = sy;
    base     = cyc;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    sync   = 1'b0;
  endtask

  initial begin
    int unsigned b;
    int unsigned bs;
    rst      = 1'b1;
    cfg_we   = 1'b0;
    cfg_ch   = '0;
    cfg_mode = '0;
    cfg_half = '0;
    cfg_duty = '0;
    sync     = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state and first TICK after release
    chk(cyc, "rst_state", 5'b11111, 5'b00000, 1'b1, 1'b0);
    rst = 1'b0;
    b = cyc;
    chk(b + 5,  "rel_led",      5'b11111, 5'b00000, 1'b1, 1'b0);
    chk(b + 8,  "rel_tick_pre", 5'b00000, 5'b00000, 1'b1, 1'b0);
    chk(b + 9,  "rel_tick_1st", 5'b00000, 5'b00000, 1'b1, 1'b1);
    chk(b + 10, "rel_tick_low", 5'b00000, 5'b00000, 1'b1, 1'b0);
    chk(b + 19, "rel_tick_2nd", 5'b00000, 5'b00000, 1'b1, 1'b1);
    wait_cyc(b + 25);

    // BLINK half=3 on CH0, aligned by SYNC
    apply(3'd0, M_BLINK, 16'd3, 8'd0, 1'b1, 1'b1);
    b = base;
    chk(b + 9,  "b3_tick_pre", 5'b00000, 5'b00000, 1'b1, 1'b0);
    chk(b + 10, "b3_tick",     5'b00000, 5'b00000, 1'b1, 1'b1);
    chk(b + 31, "b3_before",   5'b11111, 5'b00000, 1'b0, 1'b0);
    chk(b + 32, "b3_rise",     5'b11111, 5'b00001, 1'b0, 1'b0);
    chk(b + 61, "b3_high",     5'b00001, 5'b00001, 1'b0, 1'b0);
    chk(b + 62, "b3_fall",     5'b00001, 5'b00000, 1'b0, 1'b0);
    chk(b + 91, "b3_low",      5'b00001, 5'b00000, 1'b0, 1'b0);
    chk(b + 92, "b3_rise2",    5'b00001, 5'b00001, 1'b0, 1'b0);
    wait_cyc(b + 95);

    // CFG_HALF=0 on CH1 toggles every tick
    apply(3'd1, M_BLINK, 16'd0, 8'd0, 1'b1, 1'b1);
    b = base;
    chk(b + 11, "h0_low",  5'b00010, 5'b00000, 1'b0, 1'b0);
    chk(b + 12, "h0_rise", 5'b00010, 5'b00010, 1'b0, 1'b0);
    chk(b + 22, "h0_fall", 5'b00010, 5'b00000, 1'b0, 1'b0);
    chk(b + 32, "h0_rise2", 5'b00010, 5'b00010, 1'b0, 1'b0);
    wait_cyc(b + 35);

    // Mixed modes: CH0 ON, CH1 OFF, CH2 PWM 64, CH3 BLINK half=2, then SYNC
    apply(3'd0, M_ON,    16'd1, 8'd0,  1'b1, 1'b0);
    apply(3'd1, M_OFF,   16'd1, 8'd0,  1'b1, 1'b0);
    apply(3'd2, M_PWM,   16'd1, 8'd64, 1'b1, 1'b0);
    apply(3'd3, M_BLINK, 16'd2, 8'd0,  1'b1, 1'b0);
    apply(3'd0, M_OFF,   16'd0, 8'd0,  1'b0, 1'b1);
    b = base;
    for (int m = 1; m <= 256; m++) begin
      chk(b + 1 + m, "mix_pwm64", 5'b00100, ((m - 1) < 64) ? 5'b00100 : 5'b00000, 1'b0, 1'b0);
    end
    chk(b + 21, "mix_m20", 5'b11111, 5'b00101, 1'b0, 1'b0);
    chk(b + 22, "mix_m21", 5'b11111, 5'b01101, 1'b0, 1'b0);
    chk(b + 42, "mix_m41", 5'b11111, 5'b00101, 1'b0, 1'b0);
    chk(b + 62, "mix_m61", 5'b11111, 5'b01101, 1'b0, 1'b0);
    chk(b + 71, "mix_m70", 5'b11111, 5'b01001, 1'b0, 1'b0);
    chk(b + 82, "mix_m81", 5'b11111, 5'b00001, 1'b0, 1'b0);
    wait_cyc(b + 260);

    // Write/tick collision and out-of-range writes
    apply(3'd0, M_BLINK, 16'd1, 8'd0, 1'b1, 1'b1);
    b = base;
    chk(b + 12, "col_ch0_a",   5'b00001, 5'b00001, 1'b0, 1'b0);
    chk(b + 20, "col_tick",    5'b00000, 5'b00000, 1'b1, 1'b1);
    chk(b + 22, "col_ch0_b",   5'b00001, 5'b00000, 1'b0, 1'b0);
    chk(b + 22, "col_ch3_prio", 5'b01000, 5'b00000, 1'b0, 1'b0);
    chk(b + 32, "col_ch0_c",   5'b00001, 5'b00001, 1'b0, 1'b0);
    chk(b + 32, "col_ch3_clr", 5'b01000, 5'b00000, 1'b0, 1'b0);
    chk(b + 41, "col_ch3_pre", 5'b01000, 5'b00000, 1'b0, 1'b0);
    chk(b + 42, "col_ch3_rise", 5'b01000, 5'b01000, 1'b0, 1'b0);
    chk(b + 49, "oor_nochg_a", 5'b10010, 5'b00000, 1'b0, 1'b0);
    chk(b + 52, "oor_nochg_b", 5'b10010, 5'b00000, 1'b0, 1'b0);
    chk(b + 52, "oor_blink",   5'b01001, 5'b01001, 1'b0, 1'b0);
    wait_cyc(b + 20);
    apply(3'd3, M_BLINK, 16'd2, 8'd0, 1'b1, 1'b0);
    wait_cyc(b + 45);
    apply(3'd5, M_ON,  16'd1, 8'd255, 1'b1, 1'b0);
    apply(3'd7, M_PWM, 16'd1, 8'd255, 1'b1, 1'b0);
    wait_cyc(b + 60);

    // SYNC realigns two half=4 blinkers running at different phases
    apply(3'd0, M_BLINK, 16'd4, 8'd0, 1'b1, 1'b1);
    b = base;
    chk(b + 71, "sync_pre_lit", 5'b00011, 5'b00011, 1'b0, 1'b0);
    wait_cyc(b + 25);
    apply(3'd1, M_BLINK, 16'd4, 8'd0, 1'b1, 1'b0);
    wait_cyc(b + 75);
    apply(3'd0, M_OFF, 16'd0, 8'd0, 1'b0, 1'b1);
    bs = base;
    chk(bs + 2,  "sync_clear", 5'b00011, 5'b00000, 1'b0, 1'b0);
    chk(bs + 21, "sync_mid",   5'b00011, 5'b00000, 1'b0, 1'b0);
    chk(bs + 41, "sync_pre",   5'b00011, 5'b00000, 1'b0, 1'b0);
    chk(bs + 42, "sync_rise",  5'b00011, 5'b00011, 1'b0, 1'b0);
    wait_cyc(bs + 45);

    // PWM edges: duty 0 never lit, duty 255 lit 255 of 256 clocks
    apply(3'd2, M_PWM, 16'd1, 8'd0, 1'b1, 1'b1);
    b = base;
    for (int m = 1; m <= 256; m++) begin
      chk(b + 1 + m, "pwm_d0", 5'b00100, 5'b00000, 1'b0, 1'b0);
    end
    wait_cyc(b + 258);
    apply(3'd2, M_PWM, 16'd1, 8'd255, 1'b1, 1'b1);
    b = base;
    for (int m = 1; m <= 256; m++) begin
      chk(b + 1 + m, "pwm_d255", 5'b00100, ((m - 1) < 255) ? 5'b00100 : 5'b00000, 1'b0, 1'b0);
    end
    wait_cyc(b + 258);

    // Asynchronous reset mid-blink
    apply(3'd0, M_BLINK, 16'd1, 8'd0, 1'b1, 1'b1);
    b = base;
    chk(b + 12, "prerst_lit", 5'b00001, 5'b00001, 1'b0, 1'b0);
    wait_cyc(b + 13);
    rst = 1'b1;
    chk(cyc, "rst_async", 5'b11111, 5'b00000, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    b = cyc;
    chk(b + 8,  "rst2_tick_pre", 5'b00000, 5'b00000, 1'b1, 1'b0);
    chk(b + 9,  "rst2_tick_1st", 5'b00000, 5'b00000, 1'b1, 1'b1);
    chk(b + 15, "rst2_off",      5'b11111, 5'b00000, 1'b1, 1'b0);
    wait_cyc(b + 20);

    for (int k = 0; (k < 400) && (sb.size() > 0); k++) @(posedge clk);
    flush = 1'b1;
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
